// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer.
// The divider path is only built when MULDIV_DIV_EN is defined.
package muldiv_pkg;

  // Operation encodings as issued by the execute stage
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // Sequencer states
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  // HI/LO register select
  localparam logic HILO_SEL_LO = 1'b0;
  localparam logic HILO_SEL_HI = 1'b1;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Single-step datapath: 2*WIDTH working register plus one shift-add (multiply)
// or one restoring shift-subtract (divide) per step. Divide logic exists only
// when MULDIV_DIV_EN is defined.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 div_i,
  input  logic [WIDTH-1:0]     lo_init_i,   // multiplier or dividend magnitude
  input  logic [WIDTH-1:0]     operand_i,   // multiplicand or divisor magnitude
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;

  // Multiply step: add multiplicand into the upper half when the LSB is set, then shift right
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  end

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] rem_diff;
  logic           fits;

  // Divide step: shift {rem, quo} left, subtract divisor if it fits, quotient bit = fits
  always_comb begin
    rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
    rem_diff  = rem_shift - {1'b0, opnd_q};
    fits      = (rem_shift >= {1'b0, opnd_q});
    div_next  = {(fits ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], fits};
  end
`else
  logic unused_div;
  assign unused_div = div_i;
  assign div_next   = mul_next;
`endif

  // Next-state selection for the working register and held operand
  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    if (load_i) begin
      acc_d  = {{WIDTH{1'b0}}, lo_init_i};
      opnd_d = operand_i;
    end else if (step_i) begin
`ifdef MULDIV_DIV_EN
      acc_d = div_i ? div_next : mul_next;
`else
      acc_d = mul_next;
`endif
    end
  end

  // Working register state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with MFHI/MFLO/MTHI/MTLO
// access and pipeline stall. Define MULDIV_DIV_EN to build the divider path.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             hilo_rd_i,
  input  logic             hilo_we_i,
  input  logic             hilo_sel_i,
  input  logic [WIDTH-1:0] hilo_wdata_i,
  output logic [WIDTH-1:0] hilo_rdata_o,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic             div_by_zero_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, neg_q, done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               load, step, wr_res;
  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] acc, prod;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign busy_o       = (state_q != IDLE);
  assign stall_o      = busy_o & (hilo_rd_i | hilo_we_i);
  assign done_o       = done_q;
  assign hilo_rdata_o = (hilo_sel_i == HILO_SEL_HI) ? hi_q : lo_q;

  // Signed ops run on magnitudes; signs are re-applied in FIX
  always_comb begin
    sgn_a = op_is_signed(op_i) & src_a_i[WIDTH-1];
    sgn_b = op_is_signed(op_i) & src_b_i[WIDTH-1];
    mag_a = sgn_a ? -src_a_i : src_a_i;
    mag_b = sgn_b ? -src_b_i : src_b_i;
  end

  // FSM and iteration counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          load  = 1'b1;
          cnt_d = CW'(WIDTH - 1);
`ifdef MULDIV_DIV_EN
          state_d = RUN;
`else
          state_d = op_is_div(op_i) ? FIX : RUN;
`endif
        end
      end
      RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (load),
    .step_i    (step),
    .div_i     (div_q),
    .lo_init_i (op_is_div(op_i) ? mag_a : mag_b),
    .operand_i (op_is_div(op_i) ? mag_b : mag_a),
    .acc_o     (acc)
  );

`ifdef MULDIV_DIV_EN
  logic             neg_rem_q, dbz_q, dbz_pulse_q;
  logic [WIDTH-1:0] quo, rem;
  assign quo           = acc[WIDTH-1:0];
  assign rem           = acc[2*WIDTH-1:WIDTH];
  assign div_by_zero_o = dbz_pulse_q;
`else
  assign div_by_zero_o = 1'b0;
`endif

  // Sign-corrected result for the FIX write
  always_comb begin
    prod   = neg_q ? -acc : acc;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    wr_res = 1'b1;
    if (div_q) begin
`ifdef MULDIV_DIV_EN
      res_lo = dbz_q ? '1 : (neg_q ? -quo : quo);
      res_hi = neg_rem_q ? -rem : rem;
`else
      wr_res = 1'b0;
`endif
    end
  end

  // State, operation flags, HI/LO and the done pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MULDIV_DIV_EN
      neg_rem_q   <= 1'b0;
      dbz_q       <= 1'b0;
      dbz_pulse_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_q == FIX);
      if (load) begin
        div_q <= op_is_div(op_i);
        neg_q <= sgn_a ^ sgn_b;
`ifdef MULDIV_DIV_EN
        neg_rem_q <= sgn_a;
        dbz_q     <= op_is_div(op_i) & (src_b_i == '0);
`endif
      end
`ifdef MULDIV_DIV_EN
      dbz_pulse_q <= (state_q == FIX) & div_q & dbz_q;
`endif
      // MTHI/MTLO only when idle; a result write in FIX always wins
      if ((state_q == FIX) && wr_res) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (hilo_we_i && !busy_o) begin
        if (hilo_sel_i == HILO_SEL_HI) hi_q <= hilo_wdata_i;
        else                           lo_q <= hilo_wdata_i;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a result scoreboard.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        hilo_rd, hilo_we, hilo_sel;
  logic [31:0] hilo_wdata;
  logic [31:0] hilo_rdata;
  logic        busy, stall, done, div_by_zero;

  always #5 clk = ~clk;

  muldiv_ctrl #(
    .WIDTH (32)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .op_i          (op),
    .src_a_i       (src_a),
    .src_b_i       (src_b),
    .hilo_rd_i     (hilo_rd),
    .hilo_we_i     (hilo_we),
    .hilo_sel_i    (hilo_sel),
    .hilo_wdata_i  (hilo_wdata),
    .hilo_rdata_o  (hilo_rdata),
    .busy_o        (busy),
    .stall_o       (stall),
    .done_o        (done),
    .div_by_zero_o (div_by_zero)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t        sb_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    hilo_sel = HILO_SEL_LO;
    #1 lo = hilo_rdata;
    hilo_sel = HILO_SEL_HI;
    #1 hi = hilo_rdata;
    hilo_sel = HILO_SEL_LO;
  endtask

  // Issue one op, wait (bounded) for done, then score HI/LO/div_by_zero
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edbz, input int elat);
    exp_t        e;
    int          lat;
    logic [31:0] hi, lo;
    e.hi = ehi; e.lo = elo; e.dbz = edbz;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    lat = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      #1;
    end while (done !== 1'b1 && lat < 60);
    chk({tag, "_latency"}, lat, elat);
    e = sb_q.pop_front();
    if (done === 1'b1) begin
      chk({tag, "_dbz"}, div_by_zero, e.dbz);
      read_hilo(hi, lo);
      chk({tag, "_hi"}, hi, e.hi);
      chk({tag, "_lo"}, lo, e.lo);
    end
    hi_m = e.hi;
    lo_m = e.lo;
    @(negedge clk);
    #1 chk({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    logic [31:0] hi, lo;
    exp_t        e;
    int          stall_bad, early_done;

    rst = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0;
    hilo_rd = 1'b1; hilo_we = 1'b0; hilo_sel = HILO_SEL_LO; hilo_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_dbz", div_by_zero, 1'b0);
    read_hilo(hi, lo);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    rst = 1'b0;
    hilo_rd = 1'b0;

    // MTHI while idle
    @(negedge clk);
    hilo_we = 1'b1; hilo_sel = HILO_SEL_HI; hilo_wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    hilo_we = 1'b0;
    read_hilo(hi, lo);
    chk("mthi", hi, 32'hA5A5_A5A5);

    run_op("mult_4x7", OP_MULT, 32'd4, 32'd7, 32'h0, 32'h0000_001C, 1'b0, 34);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0, 34);
    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34);
`ifdef MULDIV_DIV_EN
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
    run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);
    run_op("div_zero", OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 34);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34);
`else
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, hi_m, lo_m, 1'b0, 2);
    run_op("divu", OP_DIVU, 32'd100, 32'd7, hi_m, lo_m, 1'b0, 2);
    run_op("div_zero", OP_DIV, 32'd5, 32'd0, hi_m, lo_m, 1'b0, 2);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, hi_m, lo_m, 1'b0, 2);
`endif

    // Stall behaviour: MFLO from T+5, ignored start at T+10, dropped MTLO at T+12
    @(negedge clk);
    hilo_we = 1'b1; hilo_sel = HILO_SEL_LO; hilo_wdata = 32'h1234_5678;
    @(negedge clk);
    hilo_we = 1'b0;
    #1 chk("mtlo", hilo_rdata, 32'h1234_5678);
    e.hi = 32'h0; e.lo = 32'd15; e.dbz = 1'b0;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; src_a = 32'd3; src_b = 32'd5;
    stall_bad = 0;
    early_done = 0;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      start = (k == 10);
      if (k == 10) begin
        op = OP_MULT; src_a = 32'd9; src_b = 32'd9;
      end
      hilo_rd    = (k >= 5);
      hilo_we    = (k == 12);
      hilo_sel   = HILO_SEL_LO;
      hilo_wdata = 32'hDEAD_BEEF;
      #1;
      if (k < 34 && done === 1'b1) early_done++;
      if (stall !== ((k >= 5) && (k < 34))) stall_bad++;
      if (k == 5) chk("mflo_old_value", hilo_rdata, 32'h1234_5678);
      if (k == 12) chk("mtlo_stall", stall, 1'b1);
    end
    chk("stall_window", stall_bad, 0);
    chk("stall_no_early_done", early_done, 0);
    chk("stall_done", done, 1'b1);
    e = sb_q.pop_front();
    hilo_rd = 1'b0;
    read_hilo(hi, lo);
    chk("stall_hi", hi, e.hi);
    chk("stall_lo", lo, e.lo);
    @(negedge clk);
    #1;
    chk("ignored_start_busy", busy, 1'b0);
    chk("ignored_start_done", done, 1'b0);

    // Reset mid-operation aborts with no done, then a fresh op completes
    e.hi = 32'h0; e.lo = 32'd42; e.dbz = 1'b0;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b1; op = OP_MULT; src_a = 32'd6; src_b = 32'd7;
    early_done = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 10) rst = 1'b1;
      #1;
      if (done === 1'b1) early_done++;
    end
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_done", early_done, 0);
    read_hilo(hi, lo);
    chk("rst_mid_hi", hi, 32'h0);
    chk("rst_mid_lo", lo, 32'h0);
    void'(sb_q.pop_back());
    rst = 1'b0;
    run_op("after_rst", OP_MULT, 32'hFFFF_FFFA, 32'hFFFF_FFF9, 32'h0, 32'd42, 1'b0, 34);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative multiply/divide sequencer that owns the HI/LO register pair of the MIPS core. The execute stage issues MULT/MULTU/DIV/DIVU here. The controller runs a shift-add or restoring-divide loop over WIDTH cycles and writes HI/LO on completion. It also serves MFHI/MFLO/MTHI/MTLO and stalls the pipeline when those arrive while an operation is in flight.

## Interface
- WIDTH, 32, operand and HI/LO width

- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  issue request; accepted only when busy=0
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  in  WIDTH  rs operand: multiplicand or dividend
- src_b  in  WIDTH  rt operand: multiplier or divisor
- hilo_rd  in  1  MFHI/MFLO request
- hilo_we  in  1  MTHI/MTLO request
- hilo_sel  in  1  0 = LO, 1 = HI
- hilo_wdata  in  WIDTH  MTHI/MTLO data
- hilo_rdata  out  WIDTH  selected HI or LO (combinational from registers)
- busy  out  1  operation in flight
- stall  out  1  busy & (hilo_rd | hilo_we), combinational
- done  out  1  one-cycle pulse when HI/LO are updated
- div_by_zero  out  1  one-cycle pulse with done when a DIV/DIVU had src_b=0

## Operation
- States:
  - IDLE: busy=0. Advances to RUN on start. Latches op, operand magnitudes and the sign flags.
  - RUN: iteration counter runs WIDTH-1 down to 0, one bit per cycle.
    - Multiply: conditional add plus a right shift of a 2·WIDTH accumulator.
    - Divide: restoring shift-subtract on a 2·WIDTH {remainder, quotient} register.
    - Advances to FIX when the counter reaches 0.
  - FIX: applies sign correction and writes HI/LO. Returns to IDLE.
- Signed operations compute on magnitudes:
  - MULT: 64-bit product negated when the operand signs differ.
  - DIV: quotient negated when the signs differ; remainder takes the dividend's sign.
- Results: multiply gives HI = upper WIDTH bits, LO = lower WIDTH bits. Divide gives LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = src_a unchanged, div_by_zero pulses.
- DIV of -2^31 by -1: LO = 0x80000000, HI = 0. No trap.
- start while busy=1 is ignored; there is no queue.
- hilo_we with busy=0 writes the selected register at the clock edge. With busy=1 it is dropped and stall is asserted; the pipeline must hold and retry.
- hilo_we in the same cycle as an accepted start is applied, then overwritten by the result at FIX.
- hilo_rd with busy=1 asserts stall. hilo_rdata shows the old value and must not be consumed until stall drops.
- Reset values:
  - All outputs are 0 and HI = LO = 0.
  - State returns to IDLE.
  - rst mid-operation aborts the operation with no done pulse.

## Timing
- start sampled at edge T: busy=1 from T+1 through the FIX cycle.
- RUN occupies WIDTH cycles; FIX occupies 1 cycle.
- HI/LO are written at the end of FIX. At T+WIDTH+2 (T+34 for WIDTH=32) done=1, busy=0, and hilo_rdata shows the result.
- Next start is accepted in the cycle done is high. Back-to-back issue is WIDTH+2 cycles apart.
- stall is asserted in the same cycle as the request with zero latency. It drops in the done cycle.

## Configuration
- MULDIV_DIV_EN defined: the divider path, DIV/DIVU and div_by_zero are implemented.
- MULDIV_DIV_EN undefined: no divide logic is built.
  - DIV/DIVU are accepted and complete with done at T+2.
  - HI/LO are left unchanged and div_by_zero is held at 0.
  - Multiply behaviour and latency are identical to the enabled build.

## Structure
- Package muldiv_pkg holds the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), the state enum (IDLE, RUN, FIX) and the HI/LO select constants.
- One sub-module, muldiv_iter, contains the 2·WIDTH working register and the single-step add/shift or subtract/shift datapath.
- muldiv_ctrl keeps the FSM, counter, sign handling and HI/LO registers.

## Test plan
- MULT src_a=4, src_b=7 → at T+34: done=1, LO=0x0000001C, HI=0.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- MULT -3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/7 → LO=14, HI=2.
- DIV 5/0 → LO=0xFFFFFFFF, HI=5, div_by_zero pulses with done.
- Issue MULTU, then hilo_rd=1 at T+5 → stall=1 from T+5 through T+33. Also drive start at T+10 → ignored. Also drive hilo_we at T+12 → dropped.
- Issue MULT, assert rst at T+10 → busy=0, HI=LO=0, no done. A fresh start at the next cycle completes normally.
